// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the UART-to-bus bridge: command opcodes,
// response codes, command FSM encoding and a byte-select helper.
package uart_bridge_pkg;

  localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
  localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
  localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } bridge_state_t;

  // Byte idx of a 32-bit word, idx 0 = least significant byte.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/uart_byte_link.sv
// 8N1 byte-level UART link: synchronised mid-bit-sampling receiver and a
// transmitter that accepts its next byte in the tx_done cycle for gapless output.
module uart_byte_link #(
  parameter int CLKS_PER_BIT = 512
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       rx_in,
  output logic       tx_out,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- receiver ----------------
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx_in;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        // A start bit that is high again at mid-bit was a glitch.
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_valid_d = rx_s2_q;
        rx_ferr_d  = !rx_s2_q;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_byte  = rx_sh_q;
  assign rx_valid = rx_valid_q;
  assign rx_ferr  = rx_ferr_q;

  // ---------------- transmitter ----------------
  logic             tx_busy_q, tx_busy_d;
  logic             tx_out_q, tx_out_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [8:0]       tx_sh_q, tx_sh_d;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      tx_busy_q <= 1'b0;
      tx_out_q  <= 1'b1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
    end else begin
      tx_busy_q <= tx_busy_d;
      tx_out_q  <= tx_out_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
    end
  end

  assign tx_done = tx_busy_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);

  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_out_d  = tx_out_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    if (tx_load && (!tx_busy_q || tx_done)) begin
      // Bit 0 is the start bit; the shifter holds d0..d7 then the stop bit.
      tx_busy_d = 1'b1;
      tx_out_d  = 1'b0;
      tx_cnt_d  = '0;
      tx_bit_d  = '0;
      tx_sh_d   = {1'b1, tx_byte};
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_out_d  = 1'b1;
        end else begin
          tx_out_d = tx_sh_q[0];
          tx_sh_d  = {1'b1, tx_sh_q[8:1]};
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

  assign tx_out  = tx_out_q;
  assign tx_busy = tx_busy_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// UART debug/loader bus master: parses 'R'/'W' command frames, performs one
// bus read or write, and returns read data, 'K' or '?' over the UART.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 512,
  parameter int TIMEOUT_CLKS = 10240
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        rx_in,
  output logic        tx_out,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  localparam int               GAP_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);

  logic [7:0] rx_byte, tx_byte;
  logic       rx_valid, rx_ferr, tx_load, tx_busy, tx_done;

  uart_byte_link #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_link (
    .CLK     (CLK),
    .Reset   (Reset),
    .rx_in   (rx_in),
    .tx_out  (tx_out),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr),
    .tx_byte (tx_byte),
    .tx_load (tx_load),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  bridge_state_t    state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [31:0]      cmd_addr_q, cmd_addr_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       resp_left_q, resp_left_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             err_q, err_d;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      is_wr_q     <= 1'b0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      cmd_addr_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_left_q <= '0;
      gap_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      cmd_addr_q  <= cmd_addr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_left_q <= resp_left_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    cmd_addr_d  = cmd_addr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_left_d = resp_left_q;
    gap_d       = '0;
    err_d       = 1'b0;
    tx_load     = 1'b0;
    tx_byte     = RSP_ACK;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_ferr) begin
          err_d = 1'b1;
        end else if (rx_valid) begin
          byte_cnt_d = '0;
          if (rx_byte == OP_RD || rx_byte == OP_WR) begin
            is_wr_d = (rx_byte == OP_WR);
            state_d = ST_ADDR;
          end else begin
            err_d       = 1'b1;
            tx_load     = !tx_busy;
            tx_byte     = RSP_ERR;
            resp_left_d = '0;
            state_d     = ST_RESP;
          end
        end
      end
      ST_ADDR, ST_DATA: begin
        gap_d = gap_q + 1'b1;
        if (rx_ferr) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          gap_d      = '0;
          shift_d    = {shift_q[15:0], rx_byte};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            // Bus outputs only change on entry to BUS so they hold between commands.
            if (state_q == ST_ADDR && is_wr_q) begin
              cmd_addr_d = {shift_q, rx_byte};
              state_d    = ST_DATA;
            end else begin
              if (is_wr_q) begin
                addr_d  = cmd_addr_q;
                wdata_d = {shift_q, rx_byte};
              end else begin
                addr_d = {shift_q, rx_byte};
              end
              state_d = ST_BUS;
            end
          end
        end else if (gap_q == GAP_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        tx_load     = 1'b1;
        tx_byte     = is_wr_q ? RSP_ACK : rdata[31:24];
        rdata_d     = rdata;
        resp_left_d = is_wr_q ? 2'd0 : 2'd3;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (tx_done) begin
          if (resp_left_q == 2'd0) begin
            state_d = ST_IDLE;
          end else begin
            tx_load     = 1'b1;
            tx_byte     = byte_of(rdata_q, resp_left_q - 2'd1);
            resp_left_d = resp_left_q - 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd    = (state_q == ST_BUS) && !is_wr_q;
  assign wr    = (state_q == ST_BUS) && is_wr_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign err   = err_q;
  assign busy  = (state_q != ST_IDLE) || rx_valid;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: a UART driver sends command frames, monitors
// check bus strobes and decoded response bytes against queued expectations.
module tb_uart_bus_bridge;

  localparam int CPB = 16;
  localparam int TMO = 400;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        rx_in;
  logic        tx_out;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        busy, err;

  always #5 CLK = ~CLK;

  uart_bus_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .rx_in (rx_in),
    .tx_out(tx_out),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .err   (err)
  );

  typedef struct packed {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_txn_t;

  bus_txn_t   exp_bus[$];
  logic [7:0] exp_tx[$];
  int checks = 0, errors = 0;
  int bus_cnt = 0, err_cnt = 0, cyc = 0, bus_cyc = 0;
  bit tx_mon_en = 1'b1;

  // Register-file bus slave; the bench preloads entries through pre_we.
  logic [31:0] regs [0:15];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  assign rdata = regs[addr[5:2]];
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (pre_we) regs[pre_idx] <= pre_val;
    else if (wr) regs[addr[5:2]] <= wdata;
  end

  // Bus monitor: every strobe must match the oldest expected transaction, and
  // the response start bit must appear on the very next cycle.
  initial begin : bus_mon
    bus_txn_t t;
    bit prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (prev) begin
        checks++;
        if (tx_out !== 1'b0) begin
          errors++;
          $display("FAIL tx_latency: tx_out=%b one cycle after bus strobe, expected 0", tx_out);
        end
      end
      prev = 1'b0;
      if (err === 1'b1) err_cnt++;
      if (rd === 1'b1 || wr === 1'b1) begin
        bus_cnt++;
        bus_cyc = cyc;
        prev = 1'b1;
        checks++;
        if (rd === 1'b1 && wr === 1'b1) begin
          errors++;
          $display("FAIL bus_excl: rd=1 wr=1 together, expected only one");
        end else if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: rd=%b wr=%b addr=%h, expected no access", rd, wr, addr);
        end else begin
          t = exp_bus.pop_front();
          if (wr !== t.is_wr || addr !== t.addr || (t.is_wr && wdata !== t.wdata)) begin
            errors++;
            $display("FAIL bus_txn: wr=%b addr=%h wdata=%h, expected wr=%b addr=%h wdata=%h",
                     wr, addr, wdata, t.is_wr, t.addr, t.wdata);
          end
        end
      end
    end
  end

  // UART receive model on tx_out; decoded bytes are compared against exp_tx.
  initial begin : tx_mon
    logic [7:0] b, e;
    logic       stop_b;
    forever begin
      @(negedge CLK);
      if (tx_mon_en && tx_out === 1'b0) begin
        repeat (CPB / 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = tx_out;
        end
        repeat (CPB) @(negedge CLK);
        stop_b = tx_out;
        if (tx_mon_en) begin
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: byte %h, expected no transmission", b);
          end else begin
            e = exp_tx.pop_front();
            if (b !== e || stop_b !== 1'b1) begin
              errors++;
              $display("FAIL tx_byte: got %h stop=%b, expected %h stop=1", b, stop_b, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx_in = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge CLK);
    end
    rx_in = stop_bit;
    repeat (CPB) @(negedge CLK);
    rx_in = 1'b1;
  endtask

  // Sends the low n bytes of data, most significant of them first.
  task automatic send_bytes(input logic [71:0] data, input int n);
    for (int k = 0; k < n; k++) send_byte(data[8*(n-1-k) +: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) exp_tx.push_back(w[8*k +: 8]);
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge CLK);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  // Waits for all expected bytes and for busy to drop; returns the cycle busy fell.
  task automatic wait_drain(input string name, output int end_cyc);
    int n = 0;
    while ((exp_tx.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    end_cyc = cyc;
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: tx_left=%0d busy=%b, expected 0 and 0", name, exp_tx.size(), busy);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    rx_in = 1'b1;
    repeat (4) @(negedge CLK);
    checks += 7;
    if (tx_out !== 1'b1) begin errors++; $display("FAIL rst_tx_out: got %b, expected 1", tx_out); end
    if (rd !== 1'b0)     begin errors++; $display("FAIL rst_rd: got %b, expected 0", rd); end
    if (wr !== 1'b0)     begin errors++; $display("FAIL rst_wr: got %b, expected 0", wr); end
    if (addr !== 32'h0)  begin errors++; $display("FAIL rst_addr: got %h, expected 0", addr); end
    if (wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h, expected 0", wdata); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    if (err !== 1'b0)    begin errors++; $display("FAIL rst_err: got %b, expected 0", err); end
    Reset = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_write();
    int e0 = err_cnt, b0 = bus_cnt, t_end;
    exp_bus.push_back('{is_wr: 1'b1, addr: 32'h4000_0020, wdata: 32'h0000_0003});
    exp_tx.push_back(8'h4B);
    send_byte(8'h57);
    expect_int("wr_busy_after_opcode", int'(busy), 1);
    send_bytes({32'h4000_0020, 32'h0000_0003}, 8);
    wait_drain("write", t_end);
    expect_int("wr_bus_count", bus_cnt - b0, 1);
    expect_int("wr_err_count", err_cnt - e0, 0);
    expect_int("wr_resp_span", t_end - bus_cyc, 1 + 10 * CPB);
    checks += 2;
    if (addr !== 32'h4000_0020) begin errors++; $display("FAIL wr_addr_hold: got %h, expected 40000020", addr); end
    if (regs[8] !== 32'h3) begin errors++; $display("FAIL wr_regfile: got %h, expected 00000003", regs[8]); end
  endtask

  task automatic test_read();
    int e0 = err_cnt, b0 = bus_cnt, t_end;
    preload(4'd6, 32'h0000_00A5);
    exp_bus.push_back('{is_wr: 1'b0, addr: 32'h4000_0018, wdata: 32'h0});
    push_word(32'h0000_00A5);
    send_bytes({8'h52, 32'h4000_0018}, 5);
    wait_drain("read", t_end);
    expect_int("rd_bus_count", bus_cnt - b0, 1);
    expect_int("rd_err_count", err_cnt - e0, 0);
    // Four response bytes with no idle gap between them.
    expect_int("rd_resp_span", t_end - bus_cyc, 1 + 40 * CPB);
    checks++;
    if (wdata !== 32'h3) begin errors++; $display("FAIL rd_wdata_hold: got %h, expected 00000003", wdata); end
  endtask

  task automatic test_bad_opcode();
    int e0 = err_cnt, b0 = bus_cnt, t_end;
    exp_tx.push_back(8'h3F);
    send_byte(8'h11);
    wait_drain("badop", t_end);
    expect_int("badop_err_count", err_cnt - e0, 1);
    expect_int("badop_bus_count", bus_cnt - b0, 0);
    exp_bus.push_back('{is_wr: 1'b0, addr: 32'h4000_0020, wdata: 32'h0});
    push_word(32'h0000_0003);
    send_bytes({8'h52, 32'h4000_0020}, 5);
    wait_drain("badop_recover", t_end);
    expect_int("badop_recover_bus", bus_cnt - b0, 1);
    expect_int("badop_recover_err", err_cnt - e0, 1);
  endtask

  task automatic test_framing();
    int e0 = err_cnt, b0 = bus_cnt;
    send_byte(8'h57);
    send_byte(8'h40, 1'b0);
    repeat (40) @(negedge CLK);
    expect_int("ferr_err_count", err_cnt - e0, 1);
    expect_int("ferr_busy", int'(busy), 0);
    expect_int("ferr_bus_count", bus_cnt - b0, 0);
    // Start glitch shorter than half a bit must be rejected at the mid-bit recheck.
    e0 = err_cnt;
    rx_in = 1'b0;
    repeat (CPB / 2 - 2) @(negedge CLK);
    rx_in = 1'b1;
    repeat (CPB * 12) @(negedge CLK);
    expect_int("glitch_err_count", err_cnt - e0, 0);
    expect_int("glitch_busy", int'(busy), 0);
  endtask

  task automatic test_timeout();
    int e0 = err_cnt, b0 = bus_cnt, n = 0;
    send_bytes({8'h52, 8'h40, 8'h00}, 3);
    repeat (TMO - 100) @(negedge CLK);
    expect_int("tmo_early_err", err_cnt - e0, 0);
    expect_int("tmo_early_busy", int'(busy), 1);
    while (err_cnt == e0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    expect_int("tmo_err_count", err_cnt - e0, 1);
    repeat (CPB * 12) @(negedge CLK);
    expect_int("tmo_busy", int'(busy), 0);
    expect_int("tmo_bus_count", bus_cnt - b0, 0);
  endtask

  task automatic test_back_to_back();
    int e0 = err_cnt, b0 = bus_cnt, t_end;
    exp_bus.push_back('{is_wr: 1'b1, addr: 32'h4000_0024, wdata: 32'h1234_5678});
    exp_tx.push_back(8'h4B);
    send_bytes({8'h57, 32'h4000_0024, 32'h1234_5678}, 9);
    wait_drain("b2b_write", t_end);
    exp_bus.push_back('{is_wr: 1'b0, addr: 32'h4000_0024, wdata: 32'h0});
    push_word(32'h1234_5678);
    send_bytes({8'h52, 32'h4000_0024}, 5);
    // Stray opcode arriving during the response must be discarded silently.
    send_byte(8'h57);
    wait_drain("b2b_read", t_end);
    repeat (200) @(negedge CLK);
    expect_int("b2b_stray_busy", int'(busy), 0);
    expect_int("b2b_bus_count", bus_cnt - b0, 2);
    expect_int("b2b_err_count", err_cnt - e0, 0);
  endtask

  task automatic test_reset_mid_tx();
    int n = 0, bad = 0;
    exp_bus.push_back('{is_wr: 1'b0, addr: 32'h4000_0024, wdata: 32'h0});
    exp_tx.push_back(8'h12);
    send_bytes({8'h52, 32'h4000_0024}, 5);
    while ((exp_tx.size() != 0 || tx_out !== 1'b0) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    expect_int("rstmid_reach_byte2", int'(n < 2000), 1);
    repeat (40) @(negedge CLK);
    tx_mon_en = 1'b0;
    Reset = 1'b1;
    @(negedge CLK);
    checks += 4;
    if (tx_out !== 1'b1) begin errors++; $display("FAIL rstmid_tx_out: got %b, expected 1", tx_out); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    if (rd !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: rd=%b wr=%b, expected 0 0", rd, wr); end
    if (addr !== 32'h0)  begin errors++; $display("FAIL rstmid_addr: got %h, expected 0", addr); end
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge CLK);
      if (tx_out !== 1'b1 || busy !== 1'b0 || rd !== 1'b0 || wr !== 1'b0) bad++;
    end
    expect_int("rstmid_quiet_cycles_bad", bad, 0);
    tx_mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_framing();
    test_timeout();
    test_back_to_back();
    test_reset_mid_tx();
    expect_int("leftover_tx", exp_tx.size(), 0);
    expect_int("leftover_bus", exp_bus.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
